// File: rtl/tone_wave_gen.sv
// Tone generator: phase-accumulator oscillator (triangle/saw/square/silence)
// shaped by an attack/sustain/release envelope, with a two-stage output pipeline.
module tone_wave_gen #(
  parameter int WIDTH    = 16,
  parameter int PHASE_W  = 24,
  parameter int ATK_STEP = 16,
  parameter int REL_STEP = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic                    key_on,
  input  logic [1:0]              mode,
  input  logic [PHASE_W-1:0]      tuning,
  output logic signed [WIDTH-1:0] wave_out,
  output logic                    sample_valid,
  output logic                    active
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ATTACK  = 2'd1;
  localparam logic [1:0] SUSTAIN = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [7:0] ENV_MAX = 8'd255;
  localparam logic [7:0] ENV_MIN = 8'd0;
  localparam logic [8:0] ATK_INC = 9'(ATK_STEP);
  localparam logic [8:0] REL_DEC = 9'(REL_STEP);

  localparam logic [WIDTH-1:0] HALF   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SQ_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SQ_NEG = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

  // Raw waveform from the top WIDTH phase bits; all arithmetic is mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] wave_raw(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] u);
    logic [WIDTH-1:0] dbl;
    dbl = {u[WIDTH-2:0], 1'b0};
    case (m)
      2'd0:    wave_raw = u[WIDTH-1] ? (SQ_POS - dbl) : (dbl ^ HALF);
      2'd1:    wave_raw = u ^ HALF;
      2'd2:    wave_raw = u[WIDTH-1] ? SQ_NEG : SQ_POS;
      2'd3:    wave_raw = {WIDTH{1'b0}};
      default: wave_raw = {WIDTH{1'b0}};
    endcase
  endfunction

  logic [1:0]              state_r, state_nxt_s;
  logic [7:0]              env_r, env_nxt_s, env_up_s, env_dn_s;
  logic [8:0]              atk_sum_s, rel_diff_s;
  logic                    phase_clr_s;
  logic [PHASE_W-1:0]      phase_r;
  logic signed [WIDTH-1:0] raw_r;
  logic [7:0]              env_p_r;
  logic                    valid_p_r;
  logic signed [WIDTH+8:0] prod_s;

  // Saturating envelope step candidates
  always_comb begin
    atk_sum_s  = {1'b0, env_r} + ATK_INC;
    rel_diff_s = {1'b0, env_r} - REL_DEC;
    if (atk_sum_s > {1'b0, ENV_MAX}) begin
      env_up_s = ENV_MAX;
    end else begin
      env_up_s = atk_sum_s[7:0];
    end
    if ({1'b0, env_r} > REL_DEC) begin
      env_dn_s = rel_diff_s[7:0];
    end else begin
      env_dn_s = ENV_MIN;
    end
  end

  // Envelope FSM: transitions every cycle, level steps only on ticks
  always_comb begin
    state_nxt_s = state_r;
    env_nxt_s   = env_r;
    phase_clr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_on) begin
          state_nxt_s = ATTACK;
          phase_clr_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ATTACK: begin
        if (!key_on) begin
          state_nxt_s = RELEASE;
        end else if (env_r == ENV_MAX) begin
          state_nxt_s = SUSTAIN;
        end else if (sample_tick) begin
          env_nxt_s   = env_up_s;
          state_nxt_s = (env_up_s == ENV_MAX) ? SUSTAIN : ATTACK;
        end else begin
          state_nxt_s = ATTACK;
        end
      end
      SUSTAIN: begin
        env_nxt_s = ENV_MAX;
        if (!key_on) begin
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = SUSTAIN;
        end
      end
      RELEASE: begin
        if (key_on) begin
          state_nxt_s = ATTACK;
        end else if (env_r == ENV_MIN) begin
          state_nxt_s = IDLE;
        end else if (sample_tick) begin
          env_nxt_s   = env_dn_s;
          state_nxt_s = (env_dn_s == ENV_MIN) ? IDLE : RELEASE;
        end else begin
          state_nxt_s = RELEASE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        env_nxt_s   = ENV_MIN;
      end
    endcase
  end

  // Envelope state, level and activity flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      env_r   <= ENV_MIN;
      active  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      env_r   <= env_nxt_s;
      active  <= (state_nxt_s != IDLE);
    end
  end

  // Phase accumulator, restarted when a note starts from silence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r <= {PHASE_W{1'b0}};
    end else if (phase_clr_s) begin
      phase_r <= {PHASE_W{1'b0}};
    end else if (sample_tick && (state_r != IDLE)) begin
      phase_r <= phase_r + tuning;
    end else begin
      phase_r <= phase_r;
    end
  end

  // Stage 1: capture raw sample and the envelope level it will be scaled by
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_r     <= {WIDTH{1'b0}};
      env_p_r   <= ENV_MIN;
      valid_p_r <= 1'b0;
    end else begin
      valid_p_r <= sample_tick;
      if (sample_tick) begin
        raw_r   <= wave_raw(mode, phase_r[PHASE_W-1 -: WIDTH]);
        env_p_r <= env_r;
      end else begin
        raw_r   <= raw_r;
        env_p_r <= env_p_r;
      end
    end
  end

  // env is at most 255, so the floor-shifted product always fits WIDTH bits
  assign prod_s = raw_r * $signed({1'b0, env_p_r});

  // Stage 2: scale by envelope and publish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wave_out     <= {WIDTH{1'b0}};
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= valid_p_r;
      if (valid_p_r) begin
        wave_out <= WIDTH'(prod_s >>> 8);
      end else begin
        wave_out <= wave_out;
      end
    end
  end

endmodule

// File: tb/tb_tone_wave_gen.sv
// Directed bench for tone_wave_gen: envelope ramps, waveform shapes, phase
// wrap, back-to-back ticks and asynchronous reset.
module tb_tone_wave_gen;

  logic               clk = 1'b0;
  logic               reset, sample_tick, key_on;
  logic [1:0]         mode;
  logic [23:0]        tuning;
  logic signed [15:0] wave_out;
  logic               sample_valid, active;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] ph;
  int          last_exp;
  int          e0, e1, e2;

  tone_wave_gen #(.WIDTH(16), .PHASE_W(24), .ATK_STEP(16), .REL_STEP(8)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .key_on(key_on),
    .mode(mode), .tuning(tuning), .wave_out(wave_out),
    .sample_valid(sample_valid), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected sample: raw waveform at phase top bits u, scaled by env, floor >> 8
  function automatic int model(input logic [1:0] m, input logic [15:0] u, input int e);
    int raw;
    case (m)
      2'd0:    raw = u[15] ? (98303 - 2 * int'(u)) : (2 * int'(u) - 32768);
      2'd1:    raw = int'(u) - 32768;
      2'd2:    raw = u[15] ? -32767 : 32767;
      default: raw = 0;
    endcase
    return (raw * e) >>> 8;
  endfunction

  function automatic int atk_env(input int k);
    return (16 * (k - 1) > 255) ? 255 : 16 * (k - 1);
  endfunction

  // One tick, then verify the valid pulse lands exactly two cycles later
  task automatic do_tick(input string tag, input int exp, input bit adv);
    if (adv) ph = ph + tuning;
    last_exp = exp;
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    check({tag, "_v0"}, sample_valid, 0);
    @(negedge clk);
    check({tag, "_v1"}, sample_valid, 1);
    check({tag, "_w"}, wave_out, exp);
    @(negedge clk);
    check({tag, "_v2"}, sample_valid, 0);
  endtask

  initial begin
    reset = 1'b0; sample_tick = 1'b0; key_on = 1'b0;
    mode = 2'd2; tuning = 24'h800000; ph = 24'h0;
    #1 reset = 1'b1;
    #1;
    check("rst_wave", wave_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_active", active, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Square, attack ramp into sustain
    @(negedge clk) key_on = 1'b1;
    @(negedge clk);
    check("start_active", active, 1);
    for (int k = 1; k <= 20; k++) do_tick("atk", model(mode, ph[23:8], atk_env(k)), 1'b1);

    // Sawtooth, then force the phase to 0xFFFF00 and wrap
    mode = 2'd1; tuning = 24'h000100;
    for (int k = 0; k < 4; k++) do_tick("saw", model(mode, ph[23:8], 255), 1'b1);
    tuning = 24'hFFFB00;
    do_tick("saw_jump", model(mode, ph[23:8], 255), 1'b1);
    check("wrap_setup", int'(ph), 32'hFFFF00);
    tuning = 24'h000100;
    do_tick("saw_top", 32639, 1'b1);
    do_tick("saw_wrap", -32640, 1'b1);

    repeat (5) begin
      @(negedge clk);
      check("hold_valid", sample_valid, 0);
    end
    check("hold_wave", wave_out, last_exp);

    // Three back-to-back ticks
    e0 = model(mode, ph[23:8], 255); ph = ph + tuning;
    e1 = model(mode, ph[23:8], 255); ph = ph + tuning;
    e2 = model(mode, ph[23:8], 255); ph = ph + tuning;
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("b2b_v0", sample_valid, 1); check("b2b_w0", wave_out, e0);
    @(negedge clk) sample_tick = 1'b0;
    check("b2b_v1", sample_valid, 1); check("b2b_w1", wave_out, e1);
    @(negedge clk);
    check("b2b_v2", sample_valid, 1); check("b2b_w2", wave_out, e2);
    @(negedge clk);
    check("b2b_end", sample_valid, 0);

    // Silence, then realign phase to 0 and sweep the triangle
    mode = 2'd3;
    do_tick("sil", 0, 1'b1);
    tuning = 24'h000000 - ph;
    do_tick("sil_align", 0, 1'b1);
    mode = 2'd0; tuning = 24'h400000;
    do_tick("tri_0000", -32640, 1'b1);
    do_tick("tri_4000", 0, 1'b1);
    do_tick("tri_8000", 32639, 1'b1);
    do_tick("tri_c000", -1, 1'b1);

    // Full release from sustain down to idle
    mode = 2'd2; tuning = 24'h000000;
    @(negedge clk) key_on = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      do_tick("rel", model(mode, ph[23:8], 255 - 8 * (j - 1)), 1'b1);
      if (j == 31) check("rel_active31", active, 1);
    end
    check("rel_idle", active, 0);
    do_tick("idle_tick", 0, 1'b0);

    // Attack, partial release to 103, then re-attack without phase reset
    mode = 2'd1; tuning = 24'h010000;
    @(negedge clk) key_on = 1'b1;
    ph = 24'h0;
    for (int k = 1; k <= 16; k++) do_tick("atk2", model(mode, ph[23:8], atk_env(k)), 1'b1);
    @(negedge clk) key_on = 1'b0;
    for (int j = 1; j <= 19; j++) do_tick("rel2", model(mode, ph[23:8], 255 - 8 * (j - 1)), 1'b1);
    @(negedge clk) key_on = 1'b1;
    do_tick("reatk_103", model(mode, ph[23:8], 103), 1'b1);
    do_tick("reatk_119", model(mode, ph[23:8], 119), 1'b1);

    // Reset with a sample in flight
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_wave", wave_out, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_active", active, 0);
    @(negedge clk);
    check("mid_rst_novalid", sample_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_active", active, 1);
    check("post_rst_novalid", sample_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
